// File: rtl/mapper_ram_bridge_if.sv
// Signal bundle between the CPU/mapper side, the bridge and the memory port.
// The bridge uses the slave modport; the memory-and-CPU environment uses master.
interface mapper_ram_bridge_if #(
  parameter int ADDR_W = 27
);
  logic              cpu_req;
  logic [7:0]        cpu_data_in;
  logic [ADDR_W-1:0] mapper_addr;
  logic              mapper_ram_cs;
  logic              mapper_rnw;
  logic [7:0]        cpu_data_out;
  logic              cpu_wait;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic              mem_ack;
  logic              timeout_err;

  modport slave (
    input  cpu_req, cpu_data_in, mapper_addr, mapper_ram_cs, mapper_rnw,
    input  mem_dout, mem_ack,
    output cpu_data_out, cpu_wait, mem_req, mem_addr, mem_we, mem_din,
    output timeout_err
  );

  modport master (
    output cpu_req, cpu_data_in, mapper_addr, mapper_ram_cs, mapper_rnw,
    output mem_dout, mem_ack,
    input  cpu_data_out, cpu_wait, mem_req, mem_addr, mem_we, mem_din,
    input  timeout_err
  );
endinterface

// File: rtl/mapper_ram_bridge.sv
// Turns a one-cycle CPU access pulse into a level memory request held until mem_ack.
// Optional wait timeout enabled by defining MAPPER_RAM_BRIDGE_TIMEOUT_EN.
module mapper_ram_bridge #(
  parameter int ADDR_W  = 27,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  mapper_ram_bridge_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
    $error("mapper_ram_bridge: TIMEOUT must be within 1..65535");
  end

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [7:0]        din_q, din_d;
  logic [7:0]        dout_q, dout_d;
  logic              accept;
  logic              busy;

`ifdef MAPPER_RAM_BRIDGE_TIMEOUT_EN
  localparam logic [16:0] TO_LIMIT = 17'(TIMEOUT);
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        expire;

  // Expiry is the WAIT cycle whose increment would make the count reach TIMEOUT.
  assign expire = (({1'b0, cnt_q} + 17'd1) == TO_LIMIT);
`endif

  assign accept = (state_q == S_IDLE) && bus.cpu_req && bus.mapper_ram_cs;
  assign busy   = (state_q == S_ISSUE) || (state_q == S_WAIT);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    din_d   = din_q;
    dout_d  = dout_q;
`ifdef MAPPER_RAM_BRIDGE_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = bus.mapper_addr;
          we_d    = ~bus.mapper_rnw;
          din_d   = bus.cpu_data_in;
          state_d = S_ISSUE;
`ifdef MAPPER_RAM_BRIDGE_TIMEOUT_EN
          cnt_d   = 16'd0;
`endif
        end
      end
      S_ISSUE, S_WAIT: begin
        if (bus.mem_ack) begin
          if (!we_q) dout_d = bus.mem_dout;
          state_d = S_DONE;
        end else if (state_q == S_ISSUE) begin
          state_d = S_WAIT;
        end else begin
`ifdef MAPPER_RAM_BRIDGE_TIMEOUT_EN
          if (expire) begin
            if (!we_q) dout_d = 8'hFF;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      din_q   <= 8'h00;
      dout_q  <= 8'hFF;
`ifdef MAPPER_RAM_BRIDGE_TIMEOUT_EN
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
`ifdef MAPPER_RAM_BRIDGE_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.mem_req      = busy;
  assign bus.cpu_wait     = busy || accept;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_we       = we_q;
  assign bus.mem_din      = din_q;
  assign bus.cpu_data_out = dout_q;
`ifdef MAPPER_RAM_BRIDGE_TIMEOUT_EN
  assign bus.timeout_err  = err_q;
`else
  assign bus.timeout_err  = 1'b0;
`endif
endmodule

// File: doc/mapper_ram_bridge.md
MAPPER_RAM_BRIDGE -- requirements
Module: mapper_ram_bridge

Interface
REQ-001 Parameter ADDR_W, default 27, width of the mapper RAM address and the memory address.
REQ-002 Parameter TIMEOUT, default 255, maximum wait cycles for mem_ack when the timeout feature is compiled in; legal range 1..65535.
REQ-003 Port clk  in  1  system clock; every flop updates on the rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port cpu_req  in  1  one-cycle pulse that starts a CPU memory access.
REQ-006 Port cpu_data_in  in  8  CPU write data.
REQ-007 Port mapper_addr  in  ADDR_W  translated RAM address from the mapper.
REQ-008 Port mapper_ram_cs  in  1  mapper RAM select.
REQ-009 Port mapper_rnw  in  1  mapper read-not-write; 1 selects a read.
REQ-010 Port cpu_data_out  out  8  read data returned to the CPU.
REQ-011 Port cpu_wait  out  1  CPU wait request.
REQ-012 Port mem_req  out  1  memory request level.
REQ-013 Port mem_addr  out  ADDR_W  latched memory address.
REQ-014 Port mem_we  out  1  memory write enable.
REQ-015 Port mem_din  out  8  memory write data.
REQ-016 Port mem_dout  in  8  memory read data; valid in the cycle mem_ack is high.
REQ-017 Port mem_ack  in  1  one-cycle memory completion pulse.
REQ-018 Port timeout_err  out  1  sticky timeout flag.

Function
REQ-019 The block SHALL implement an FSM with the states IDLE, ISSUE, WAIT and DONE.
REQ-020 IDLE: when cpu_req and mapper_ram_cs are both high, the block SHALL latch mapper_addr into mem_addr, ~mapper_rnw into mem_we and cpu_data_in into mem_din, then go to ISSUE.
REQ-021 In that same IDLE accept cycle, cpu_wait SHALL be high combinationally.
REQ-022 IDLE: cpu_req with mapper_ram_cs low SHALL cause no state change and no output change.
REQ-023 ISSUE and WAIT: mem_req SHALL be high and cpu_wait SHALL be high.
REQ-024 ISSUE SHALL always advance to WAIT on the next edge.
REQ-025 mem_ack SHALL be sampled in both ISSUE and WAIT.
REQ-026 On mem_ack: if mem_we is 0, the block SHALL register mem_dout into cpu_data_out; the FSM SHALL then go to DONE.
REQ-027 DONE: mem_req and cpu_wait SHALL be low for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-028 Minimum latency: cpu_req in cycle 0, mem_req high in cycle 1, ack in cycle 1, and cpu_wait low in cycle 2 with read data valid.
REQ-029 cpu_data_out SHALL hold its value until the next completed read; writes SHALL NOT alter it.
REQ-030 cpu_req in any state other than IDLE SHALL be ignored.
REQ-031 mem_ack in IDLE or DONE SHALL be ignored.
REQ-032 mem_addr, mem_we and mem_din SHALL remain stable from ISSUE through DONE.

Reset
REQ-033 On reset, the FSM SHALL go to IDLE.
REQ-034 On reset: mem_req=0, cpu_wait=0, mem_we=0, mem_addr=0, mem_din=0, cpu_data_out=8'hFF, timeout_err=0, wait counter=0.
REQ-035 A reset asserted mid-access SHALL abort the access, with mem_req low in the first cycle after the reset edge.

Configuration
REQ-036 Macro MAPPER_RAM_BRIDGE_TIMEOUT_EN defined: a 16-bit counter SHALL clear on entry to ISSUE and increment each WAIT cycle without mem_ack.
REQ-037 With the macro defined, when the counter reaches TIMEOUT the FSM SHALL go to DONE; on a read it SHALL load cpu_data_out=8'hFF; it SHALL set timeout_err=1, which is cleared only by reset.
REQ-038 With the macro defined, a mem_ack arriving in the same cycle as expiry SHALL take priority: normal completion, no error.
REQ-039 Macro not defined: no counter SHALL exist, WAIT SHALL persist until mem_ack, and timeout_err SHALL be tied to 0.

Verification
REQ-040 Read: mapper_addr=27'h0012345, rnw=1, ram_cs=1, cpu_req pulse; mem_ack with mem_dout=8'hA5 in cycle 3 -> mem_req high cycles 1-3, cpu_data_out=8'hA5 and cpu_wait=0 in cycle 4.
REQ-041 Write: rnw=0, cpu_data_in=8'h3C -> mem_we=1 and mem_din=8'h3C throughout ISSUE..DONE; cpu_data_out unchanged.
REQ-042 cpu_req with ram_cs=0 -> mem_req stays 0 and cpu_wait stays 0; second cpu_req while in WAIT -> exactly one mem_req assertion.
REQ-043 Reset in WAIT -> mem_req=0 and cpu_data_out=8'hFF after the edge; a late mem_ack afterwards is ignored.
REQ-044 With MAPPER_RAM_BRIDGE_TIMEOUT_EN and TIMEOUT=4, read with no ack -> DONE after 4 WAIT cycles, cpu_data_out=8'hFF, timeout_err=1; ack in the expiry cycle -> no error.
